rec_play_ctrl: RTL and testbench
================================

Name: rec_play_ctrl

Overview:
- Sequences record and playback of a serial 1-bit audio stream through word-wide memory (32-bit words).
- Record: packs one bit per clock into 32-bit words and writes them to consecutive addresses from 0.
- Playback: reads the stored words back and serialises them one bit per clock.
- Sits between the button front-end and the sample memory. Owns the bit counter, the write/read address pointers and the recorded length.

Parameters:
ADDR_W, 10, memory address width; DEPTH = 2**ADDR_W words

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
Rec_butt  input  1  one-cycle record request pulse (debounced upstream)
Play_butt  input  1  one-cycle playback request pulse (debounced upstream)
bit_in  input  1  serial record bit, sampled every RECORD cycle
mem_addr  output  ADDR_W  memory word address
mem_we  output  1  write strobe, one cycle per word
mem_wdata  output  32  write word
mem_re  output  1  read strobe
mem_rdata  input  32  read word, valid the cycle after mem_re
bit_out  output  1  serial playback bit
bit_out_valid  output  1  high while bit_out carries stored data
recording  output  1  high in RECORD
playing  output  1  high in PLAY_FETCH/PLAY
full  output  1  memory filled by last recording
word_count  output  ADDR_W+1  words stored by last recording (0..DEPTH)

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; shift register, bit counter and pointers 0.
- States: IDLE, RECORD, PLAY_FETCH, PLAY. All outputs registered.
- Button priority: Rec_butt beats Play_butt when both are high in the same cycle.
- IDLE + Rec_butt:
  - -> RECORD; clears bit counter, wr_addr, word_count and full.
  - First bit_in is sampled the following cycle.
- RECORD, every cycle:
  - shreg <= {shreg[30:0], bit_in}; the first bit received ends in bit 31.
  - 5-bit counter increments, wrapping 31->0.
  - When counter==31 (32nd bit): next cycle mem_we=1, mem_addr=wr_addr, mem_wdata=completed word; then wr_addr++, word_count++.
- RECORD stop:
  - Rec_butt -> IDLE; partial word discarded; word_count = complete words written.
  - Play_butt is ignored in RECORD.
- RECORD full: after the write to address DEPTH-1 -> IDLE, full=1, word_count=DEPTH. wr_addr does not wrap.
- IDLE + Play_butt:
  - word_count==0: stay IDLE, no mem_re.
  - Otherwise -> PLAY_FETCH; rd_addr=0; mem_re=1 at address 0 for one cycle.
- PLAY_FETCH: the cycle after mem_re, load shreg from mem_rdata; -> PLAY with counter=0.
- PLAY, every cycle:
  - bit_out = shreg[31], bit_out_valid=1; shift left; counter increments.
- PLAY prefetch:
  - At counter==30, if rd_addr+1 < word_count: mem_re=1, mem_addr=rd_addr+1.
  - At counter==31 the prefetched word loads into shreg so output continues gaplessly; rd_addr++.
- PLAY end: at counter==31 of word word_count-1 -> IDLE; bit_out_valid drops the next cycle.
- PLAY aborts:
  - Play_butt -> IDLE immediately.
  - Rec_butt -> RECORD (same entry as from IDLE).
- mem_we and mem_re are never high together. mem_addr holds its last value when both are low.
- Reset mid-operation: abort immediately, no write completes, word_count=0. Memory contents are undefined to this block.

Optional Feature:
LOOP_PLAY_EN
- Defined: at the end of the last word, playback wraps to address 0. The read of word 0 is issued at counter==30, and playback continues gaplessly until Play_butt or Rec_butt.
- Undefined: playback stops at the last word as above.

Test Plan:
- Reset low mid-RECORD after 40 bits -> all outputs 0, state IDLE, word_count=0, no further mem_we.
- Rec_butt, feed 0xA5A5A5A5 then 0x12345678 MSB-first, then Rec_butt -> mem_we at addr 0 with 0xA5A5A5A5 and at addr 1 with 0x12345678, word_count=2.
- After 2-word record, Play_butt with memory model (1-cycle latency) -> 64 consecutive bit_out_valid cycles reproducing the bits, no gap at word boundary, then IDLE.
- ADDR_W=2, record continuously -> exactly 4 writes to addr 0..3, then full=1, word_count=4, recording=0.
- Rec_butt and Play_butt in same IDLE cycle -> RECORD entered; Play_butt with word_count=0 -> no mem_re, stays IDLE.
- LOOP_PLAY_EN defined, 1-word recording 0x80000001 -> bit pattern repeats every 32 cycles with mem_re at addr 0 each loop until Play_butt.

Source files
------------

// File: rtl/rec_play_ctrl.sv
// rec_play_ctrl: records a serial bit stream into 32-bit memory words and plays it back gaplessly
//   clk, reset (async active-low)     : clock and reset
//   Rec_butt, Play_butt               : one-cycle requests; record wins when both are high
//   bit_in                            : serial record bit, sampled every RECORD cycle
//   mem_addr/mem_we/mem_wdata/mem_re  : word memory port; mem_rdata is valid the cycle after mem_re
//   bit_out, bit_out_valid            : serial playback stream
//   recording, playing, full, word_count : status of the controller and of the last recording
//   Define LOOP_PLAY_EN to make playback wrap to word 0 until a button stops it.
module rec_play_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Rec_butt,
  input  logic              Play_butt,
  input  logic              bit_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              bit_out,
  output logic              bit_out_valid,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY_FETCH, S_PLAY} state_e;
  state_e            state_q;
  logic [31:0]       shreg_q, wdata_q;
  logic [4:0]        cnt_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q, addr_q, nxt_addr;
  logic [ADDR_W:0]   wc_q, rd_nxt;
  logic              we_q, re_q, bit_q, valid_q, rec_q, play_q, full_q;
  logic              last_word, more;
  assign rd_nxt    = {1'b0, rd_addr_q} + (ADDR_W+1)'(1);
  assign last_word = rd_nxt >= wc_q;
`ifdef LOOP_PLAY_EN
  assign more     = 1'b1;
  assign nxt_addr = last_word ? '0 : rd_nxt[ADDR_W-1:0];
`else
  assign more     = !last_word;
  assign nxt_addr = rd_nxt[ADDR_W-1:0];
`endif
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign mem_re        = re_q;
  assign bit_out       = bit_q;
  assign bit_out_valid = valid_q;
  assign recording     = rec_q;
  assign playing       = play_q;
  assign full          = full_q;
  assign word_count    = wc_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      addr_q    <= '0;
      wc_q      <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      bit_q     <= 1'b0;
      valid_q   <= 1'b0;
      rec_q     <= 1'b0;
      play_q    <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      if (Rec_butt && state_q != S_RECORD) begin
        state_q   <= S_RECORD;
        cnt_q     <= '0;
        wr_addr_q <= '0;
        wc_q      <= '0;
        full_q    <= 1'b0;
        rec_q     <= 1'b1;
        play_q    <= 1'b0;
        bit_q     <= 1'b0;
        valid_q   <= 1'b0;
      end else case (state_q)
        S_IDLE: begin
          bit_q   <= 1'b0;
          valid_q <= 1'b0;
          if (Play_butt && wc_q != '0) begin
            state_q   <= S_PLAY_FETCH;
            rd_addr_q <= '0;
            addr_q    <= '0;
            re_q      <= 1'b1;
            play_q    <= 1'b1;
          end
        end
        S_RECORD: begin
          if (Rec_butt) begin
            state_q <= S_IDLE;
            rec_q   <= 1'b0;
          end else begin
            shreg_q <= {shreg_q[30:0], bit_in};
            cnt_q   <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              we_q    <= 1'b1;
              addr_q  <= wr_addr_q;
              wdata_q <= {shreg_q[30:0], bit_in};
              wc_q    <= wc_q + (ADDR_W+1)'(1);
              // the last address ends the recording instead of wrapping the pointer
              if (wr_addr_q == '1) begin
                state_q <= S_IDLE;
                rec_q   <= 1'b0;
                full_q  <= 1'b1;
              end else wr_addr_q <= wr_addr_q + ADDR_W'(1);
            end
          end
        end
        S_PLAY_FETCH: begin
          if (Play_butt) begin
            state_q <= S_IDLE;
            play_q  <= 1'b0;
          end else if (!re_q) begin
            // re_q low means the read strobe has passed and mem_rdata now holds word 0
            shreg_q <= mem_rdata;
            cnt_q   <= '0;
            state_q <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (Play_butt) begin
            state_q <= S_IDLE;
            play_q  <= 1'b0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
          end else begin
            bit_q   <= shreg_q[31];
            valid_q <= 1'b1;
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q + 5'd1;
            // strobe lands while cnt is 30 so the word is ready for the reload at cnt 31
            if (cnt_q == 5'd29 && more) begin
              re_q   <= 1'b1;
              addr_q <= nxt_addr;
            end
            if (cnt_q == 5'd31) begin
              if (more) begin
                shreg_q   <= mem_rdata;
                rd_addr_q <= nxt_addr;
              end else begin
                state_q <= S_IDLE;
                play_q  <= 1'b0;
              end
            end
          end
        end
      endcase
    end
endmodule

// File: tb/tb_rec_play_ctrl.sv
// tb_rec_play_ctrl: scoreboard bench for rec_play_ctrl with a 1-cycle-latency word memory
module tb_rec_play_ctrl;
  localparam int AW = 2;
  logic          clk = 0, reset = 0, Rec_butt = 0, Play_butt = 0, bit_in = 0;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re, bit_out, bit_out_valid, recording, playing, full;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic [AW:0]   word_count;
  logic [31:0]   mem [4];
  logic [31:0]   wv [4];
  logic [AW+31:0] wq[$];
  logic [AW-1:0]  rq[$];
  logic           bq[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  rec_play_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .Rec_butt(Rec_butt), .Play_butt(Play_butt), .bit_in(bit_in),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .bit_out(bit_out), .bit_out_valid(bit_out_valid),
    .recording(recording), .playing(playing), .full(full), .word_count(word_count)
  );
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (reset) begin
    chk("we_re_exclusive", {63'd0, mem_we & mem_re}, 0);
    if (mem_we) begin
      chk("mem_we_expected", {63'd0, wq.size() != 0}, 1);
      if (wq.size() != 0) chk("mem_write", {mem_addr, mem_wdata}, wq.pop_front());
    end
    if (mem_re) begin
      chk("mem_re_expected", {63'd0, rq.size() != 0}, 1);
      if (rq.size() != 0) chk("mem_read_addr", mem_addr, rq.pop_front());
    end
    if (bit_out_valid) begin
      chk("bit_expected", {63'd0, bq.size() != 0}, 1);
      if (bq.size() != 0) chk("bit_out", bit_out, bq.pop_front());
    end
  end
  task automatic pulse_rec;
    Rec_butt = 1; @(posedge clk); #1; Rec_butt = 0;
  endtask
  task automatic pulse_play;
    Play_butt = 1; @(posedge clk); #1; Play_butt = 0;
  endtask
  task automatic feed(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) begin
      bit_in = w[i]; @(posedge clk); #1;
    end
  endtask
  task automatic push_play(input int nw);
    for (int k = 0; k < nw; k++) begin
      rq.push_back(AW'(k));
      for (int i = 31; i >= 0; i--) bq.push_back(wv[k][i]);
    end
  endtask
  task automatic wait_start;
    int n = 0;
    do begin @(negedge clk); n++; end while (!bit_out_valid && n < 20);
    chk("play_start", bit_out_valid, 1);
  endtask
  task automatic play_check(input int nw);
    int run = 0;
    push_play(nw);
    pulse_play;
    wait_start;
    while (bit_out_valid && run < 300) begin run++; @(negedge clk); end
    chk("play_len", run, nw * 32);
    chk("play_done", playing, 0);
    chk("reads_left", rq.size(), 0);
    chk("bits_left", bq.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit=200000", $time);
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", {mem_addr, mem_we, mem_wdata, mem_re, bit_out, bit_out_valid,
                          recording, playing, full, word_count}, 0);
    reset = 1;
    @(posedge clk); #1;
    Rec_butt = 1; Play_butt = 1; @(posedge clk); #1; Rec_butt = 0; Play_butt = 0;
    chk("both_recording", recording, 1);
    chk("both_playing", playing, 0);
    pulse_rec;
    chk("empty_recording", recording, 0);
    chk("empty_wc", word_count, 0);
    pulse_play;
    repeat (4) @(posedge clk); #1;
    chk("empty_play", playing, 0);
    wv[0] = 32'hA5A5A5A5; wv[1] = 32'h12345678;
    wq.push_back({AW'(0), wv[0]}); wq.push_back({AW'(1), wv[1]});
    pulse_rec;
    feed(wv[0]); feed(wv[1]);
    pulse_rec;
    chk("rec2_wc", word_count, 2);
    chk("rec2_full", full, 0);
    chk("rec2_recording", recording, 0);
    chk("rec2_writes_left", wq.size(), 0);
`ifndef LOOP_PLAY_EN
    play_check(2);
`endif
    wq.push_back({AW'(0), 32'hDEADBEEF});
    pulse_rec;
    feed(32'hDEADBEEF);
    for (int i = 0; i < 8; i++) begin bit_in = i[0]; @(posedge clk); #1; end
    reset = 0; #1;
    chk("reset_mid_outs", {mem_addr, mem_we, mem_wdata, mem_re, bit_out, bit_out_valid,
                           recording, playing, full, word_count}, 0);
    repeat (3) @(posedge clk); #1;
    reset = 1;
    feed(32'hFFFF0000);
    chk("reset_mid_recording", recording, 0);
    chk("reset_mid_wc", word_count, 0);
    chk("reset_mid_writes_left", wq.size(), 0);
    wv[0] = 32'h0F0F0F0F; wv[1] = 32'hF0000001; wv[2] = 32'h13579BDF; wv[3] = 32'hCAFEF00D;
    for (int k = 0; k < 4; k++) wq.push_back({AW'(k), wv[k]});
    pulse_rec;
    for (int k = 0; k < 4; k++) feed(wv[k]);
    feed(32'hFFFFFFFF);
    chk("full_flag", full, 1);
    chk("full_wc", word_count, 4);
    chk("full_recording", recording, 0);
    chk("full_writes_left", wq.size(), 0);
`ifndef LOOP_PLAY_EN
    play_check(4);
`else
    begin
      int run = 0;
      wv[0] = 32'h80000001;
      wq.push_back({AW'(0), wv[0]});
      pulse_rec;
      feed(wv[0]);
      pulse_rec;
      chk("loop_wc", word_count, 1);
      chk("loop_full", full, 0);
      for (int l = 0; l < 3; l++) push_play(1);
      rq.push_back(AW'(0));
      pulse_play;
      wait_start;
      while (bit_out_valid && run < 96) begin
        run++;
        if (run < 96) @(negedge clk);
      end
      chk("loop_len", run, 96);
      Play_butt = 1; @(posedge clk); #1; Play_butt = 0;
      chk("loop_stop_valid", bit_out_valid, 0);
      chk("loop_stop_playing", playing, 0);
      chk("loop_reads_left", rq.size(), 0);
      chk("loop_bits_left", bq.size(), 0);
    end
`endif
    repeat (3) @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
